// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse bring-up sequencer.
// Holds the sequencer state enum, the mouse command/response bytes and the
// controller status bit positions, plus helpers that describe each transaction.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH  = 3'd0,
    ST_SEND   = 3'd1,
    ST_TXWAIT = 3'd2,
    ST_RXWAIT = 3'd3,
    ST_READ   = 3'd4,
    ST_DONE   = 3'd5,
    ST_FAIL   = 3'd6
  } ps2_state_t;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
  localparam logic [7:0] PS2_MOUSE_ID   = 8'h00;

  // Bit positions inside the controller status word (read with bytesel 10).
  localparam int PS2_ST_RX_NEMPTY = 8;
  localparam int PS2_ST_ERR       = 9;
  localparam int PS2_ST_TX_BUSY   = 10;

  // Script steps: 0 send FF, 1..3 expect FA/AA/00, 4 send F4, 5 expect FA.
  localparam logic [2:0] PS2_STEP_ENABLE = 3'd4;
  localparam logic [2:0] PS2_STEP_LAST   = 3'd5;

  // One sequencer-issued register access.
  typedef struct packed {
    logic        wr;
    logic [1:0]  bytesel;
    logic [15:0] dat;
  } ps2_txn_t;

  // Byte sent or expected at a given script step.
  function automatic logic [7:0] ps2_script_byte(input logic [2:0] step);
    case (step)
      3'd0:    ps2_script_byte = PS2_CMD_RESET;
      3'd1:    ps2_script_byte = PS2_ACK;
      3'd2:    ps2_script_byte = PS2_BAT_OK;
      3'd3:    ps2_script_byte = PS2_MOUSE_ID;
      3'd4:    ps2_script_byte = PS2_CMD_ENABLE;
      3'd5:    ps2_script_byte = PS2_ACK;
      default: ps2_script_byte = 8'h00;
    endcase
  endfunction

  // Register access that a state issues on the controller port.
  function automatic ps2_txn_t ps2_txn(input ps2_state_t st, input logic [2:0] step);
    ps2_txn_t t;
    t = '0;
    case (st)
      ST_FLUSH:  begin t.wr = 1'b1; t.bytesel = 2'b10; t.dat = 16'h8000; end
      ST_SEND:   begin t.wr = 1'b1; t.bytesel = 2'b01; t.dat = {8'h00, ps2_script_byte(step)}; end
      ST_TXWAIT: begin t.wr = 1'b0; t.bytesel = 2'b10; end
      ST_RXWAIT: begin t.wr = 1'b0; t.bytesel = 2'b10; end
      ST_READ:   begin t.wr = 1'b0; t.bytesel = 2'b11; end
      default:   t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ps2_port_mux.sv
// Ownership mux for the mouse controller register port.
// Zero latency: pure combinational selection between upstream and sequencer.
// While the sequencer owns the port, upstream accesses see no ack (they stall).
module ps2_port_mux (
  input  logic        pass_i,
  input  logic        cs_i,
  input  logic        access_i,
  input  logic        wr_en_i,
  input  logic [15:0] data_i,
  input  logic [1:0]  bytesel_i,
  input  logic        seq_strb_i,
  input  logic        seq_wr_en_i,
  input  logic [15:0] seq_data_i,
  input  logic [1:0]  seq_bytesel_i,
  input  logic        m_ack_i,
  input  logic [15:0] m_data_i,
  output logic        m_cs_o,
  output logic        m_access_o,
  output logic        m_wr_en_o,
  output logic [15:0] m_data_o,
  output logic [1:0]  m_bytesel_o,
  output logic        up_ack_o,
  output logic [15:0] up_data_o
);

  // Forward upstream verbatim in pass-through, otherwise drive the sequencer strobe.
  always_comb begin
    m_cs_o      = seq_strb_i;
    m_access_o  = seq_strb_i;
    m_wr_en_o   = seq_wr_en_i;
    m_data_o    = seq_data_i;
    m_bytesel_o = seq_bytesel_i;
    up_ack_o    = 1'b0;
    up_data_o   = 16'h0000;
    if (pass_i) begin
      m_cs_o      = cs_i;
      m_access_o  = access_i;
      m_wr_en_o   = wr_en_i;
      m_data_o    = data_i;
      m_bytesel_o = bytesel_i;
      up_ack_o    = m_ack_i;
      up_data_o   = m_data_i;
    end
  end

endmodule

// File: rtl/ps2_mouse_init_sequencer.sv
// PS/2 mouse bring-up: flush, reset (FF), check FA/AA/00, enable (F4), check FA.
// Each controller access is a 1-cycle strobe followed by the ack cycle; polls run back-to-back.
// Upstream is stalled until DONE/FAIL, then passed through with no added latency.
module ps2_mouse_init_sequencer
  import ps2_pkg::*;
#(
  parameter int clkf        = 50000000,
  parameter int timeout_ms  = 750,
  parameter int max_retries = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        cs,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_out,
  input  logic [15:0] data_m_data_in,
  input  logic [1:0]  data_m_bytesel,
  output logic        m_cs,
  output logic        m_access,
  output logic        m_wr_en,
  input  logic        m_ack,
  input  logic [15:0] m_data_in,
  output logic [15:0] m_data_out,
  output logic [1:0]  m_bytesel,
  output logic        init_done,
  output logic        init_failed
);

  localparam int TMO_LIMIT = clkf / 1000 * timeout_ms;
  localparam int TW        = $clog2(TMO_LIMIT) + 1;
  localparam int RW        = $clog2(max_retries + 1) + 1;
  localparam logic [TW-1:0] TMO_MAX   = TW'(TMO_LIMIT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(max_retries);

  ps2_state_t    state_q, nxt_state_d;
  logic [2:0]    step_q, nxt_step_d;
  logic [RW-1:0] retries_q, nxt_retries_d;
  logic [TW-1:0] tmo_q;
  logic          busy_q;      // a strobe has been issued and its ack is outstanding
  logic          strb_q;      // strobe cycle of a sequencer transaction
  ps2_txn_t      txn_q;
  logic          init_done_q, init_failed_q;
  logic          rst_pend_q;  // restart seen while an upstream access was in flight

  logic pass, timed_state, nxt_timed, tmo_hit, bad_resp, ack_ok, take_restart;

  assign pass         = (state_q == ST_DONE) || (state_q == ST_FAIL);
  assign timed_state  = (state_q == ST_TXWAIT) || (state_q == ST_RXWAIT);
  assign nxt_timed    = (nxt_state_d == ST_TXWAIT) || (nxt_state_d == ST_RXWAIT);
  assign tmo_hit      = (tmo_q >= TMO_MAX);
  // Ack only belongs to us after our strobe cycle has passed.
  assign ack_ok       = busy_q && !strb_q && m_ack;
  // A restart waits for any upstream access to finish (its ack cycle is the last one).
  assign take_restart = (restart || rst_pend_q) && (!(cs && data_m_access) || m_ack);

  // Timeout is judged at the poll's ack, so the port is never abandoned mid-transaction.
  assign bad_resp = (timed_state && tmo_hit) ||
                    ((state_q == ST_READ) &&
                     (m_data_in[PS2_ST_ERR] || (m_data_in[7:0] != ps2_script_byte(step_q))));

  // Next state/step/retry count, applied when the current transaction acks.
  always_comb begin
    nxt_state_d   = state_q;
    nxt_step_d    = step_q;
    nxt_retries_d = retries_q;
    if (bad_resp) begin
      if (retries_q < RETRY_MAX) begin
        nxt_state_d   = ST_FLUSH;
        nxt_step_d    = 3'd0;
        nxt_retries_d = retries_q + 1'b1;
      end else begin
        nxt_state_d = ST_FAIL;
      end
    end else begin
      case (state_q)
        ST_FLUSH: nxt_state_d = ST_SEND;
        ST_SEND: begin
          nxt_state_d = ST_TXWAIT;
          nxt_step_d  = step_q + 3'd1;
        end
        ST_TXWAIT: if (!m_data_in[PS2_ST_TX_BUSY])  nxt_state_d = ST_RXWAIT;
        ST_RXWAIT: if (m_data_in[PS2_ST_RX_NEMPTY]) nxt_state_d = ST_READ;
        ST_READ: begin
          if (step_q == PS2_STEP_LAST) begin
            nxt_state_d = ST_DONE;
          end else begin
            nxt_step_d  = step_q + 3'd1;
            nxt_state_d = (step_q + 3'd1 == PS2_STEP_ENABLE) ? ST_SEND : ST_RXWAIT;
          end
        end
        default: nxt_state_d = state_q;
      endcase
    end
  end

  // Sequencer FSM: issues strobes, walks the script, owns status and restart handling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FLUSH;
      step_q        <= 3'd0;
      retries_q     <= '0;
      tmo_q         <= '0;
      busy_q        <= 1'b0;
      strb_q        <= 1'b0;
      txn_q         <= '0;
      init_done_q   <= 1'b0;
      init_failed_q <= 1'b0;
      rst_pend_q    <= 1'b0;
    end else begin
      strb_q <= 1'b0;
      if (pass) begin
        if (take_restart) begin
          state_q       <= ST_FLUSH;
          step_q        <= 3'd0;
          retries_q     <= '0;
          busy_q        <= 1'b0;
          init_done_q   <= 1'b0;
          init_failed_q <= 1'b0;
          rst_pend_q    <= 1'b0;
        end else if (restart) begin
          rst_pend_q <= 1'b1;
        end
      end else begin
        if (timed_state && !tmo_hit) tmo_q <= tmo_q + 1'b1;
        if (!busy_q) begin
          // First transaction after reset or restart.
          busy_q <= 1'b1;
          strb_q <= 1'b1;
          txn_q  <= ps2_txn(state_q, step_q);
        end else if (ack_ok) begin
          state_q   <= nxt_state_d;
          step_q    <= nxt_step_d;
          retries_q <= nxt_retries_d;
          if (nxt_timed && (nxt_state_d != state_q)) tmo_q <= '0;
          if ((nxt_state_d == ST_DONE) || (nxt_state_d == ST_FAIL)) begin
            busy_q        <= 1'b0;
            txn_q         <= '0;
            init_done_q   <= (nxt_state_d == ST_DONE);
            init_failed_q <= (nxt_state_d == ST_FAIL);
          end else begin
            // Next strobe goes out right after the ack: one transaction per 2 cycles.
            strb_q <= 1'b1;
            txn_q  <= ps2_txn(nxt_state_d, nxt_step_d);
          end
        end
      end
    end
  end

  assign init_done   = init_done_q;
  assign init_failed = init_failed_q;

  ps2_port_mux u_mux (
    .pass_i        (pass),
    .cs_i          (cs),
    .access_i      (data_m_access),
    .wr_en_i       (data_m_wr_en),
    .data_i        (data_m_data_in),
    .bytesel_i     (data_m_bytesel),
    .seq_strb_i    (strb_q),
    .seq_wr_en_i   (txn_q.wr),
    .seq_data_i    (txn_q.dat),
    .seq_bytesel_i (txn_q.bytesel),
    .m_ack_i       (m_ack),
    .m_data_i      (m_data_in),
    .m_cs_o        (m_cs),
    .m_access_o    (m_access),
    .m_wr_en_o     (m_wr_en),
    .m_data_o      (m_data_out),
    .m_bytesel_o   (m_bytesel),
    .up_ack_o      (data_m_ack),
    .up_data_o     (data_m_data_out)
  );

endmodule

// File: doc/ps2_mouse_init_sequencer.md
# ps2_mouse_init_sequencer

Sits between the CPU data bus and the PS/2 mouse controller register port and owns that port after reset. It performs the mouse bring-up sequence in hardware: flush, reset command 0xFF, expect ACK/BAT/ID, enable reporting 0xF4, expect ACK. It then hands the port to the CPU as a transparent pass-through. It retries on timeout or a bad response, and reports success or failure on status outputs.

## Interface
- clkf, 50000000: clock frequency in Hz, used to scale the timeout.
- timeout_ms, 750: per-response timeout in milliseconds; covers the mouse BAT time of 500 ms or less.
- max_retries, 3: full-sequence restarts allowed before failing.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- restart  in  1  single-cycle pulse; reruns the sequence from FLUSH.
- cs  in  1  upstream chip select.
- data_m_access  in  1  upstream access; held until ack.
- data_m_wr_en  in  1  upstream write.
- data_m_ack  out  1  upstream ack.
- data_m_data_out  out  16  upstream read data.
- data_m_data_in  in  16  upstream write data.
- data_m_bytesel  in  2  upstream byte select.
- m_cs  out  1  chip select to the mouse controller.
- m_access  out  1  access to the mouse controller.
- m_wr_en  out  1  write enable to the mouse controller.
- m_ack  in  1  ack from the mouse controller.
- m_data_in  in  16  read data from the mouse controller: [15:8] status, [7:0] FIFO byte.
- m_data_out  out  16  write data to the mouse controller.
- m_bytesel  out  2  byte select to the mouse controller.
- init_done  out  1  sequence succeeded; port is in pass-through.
- init_failed  out  1  retries exhausted; port is in pass-through.

## Operation
- Mouse controller map:
  - Write with bytesel[0] transmits data[7:0].
  - Write with bytesel[1] and data[15]=1 flushes the RX FIFO.
  - Read with bytesel[1] returns status: bit8 rx-not-empty, bit9 error, bit10 tx_busy.
  - Read with bytesel[0] pops the FIFO. The pop happens whenever cs is high, so m_cs is never asserted outside a sequencer-issued transaction.
- Sequencer transactions: m_cs, m_access and the drive signals are asserted for exactly one cycle. The sequencer then waits for m_ack and samples m_data_in on the cycle m_ack is high.
- States:
  - FLUSH: write 0x8000 with bytesel 10.
  - SEND: write the command byte with bytesel 01.
  - TXWAIT: status read with bytesel 10, repeated until bit10 is 0.
  - RXWAIT: status read, repeated until bit8 is 1.
  - READ: read with bytesel 11 and compare [7:0] to the expected byte.
  - DONE.
  - FAIL.
- Expected script: send 0xFF, then expect 0xFA, 0xAA, 0x00; send 0xF4, then expect 0xFA; then DONE. A 3-bit step index walks the script.
- Mismatch, or status bit9 set during READ:
  - If retries < max_retries: retries++ and go to FLUSH.
  - Otherwise go to FAIL.
- Timeout:
  - The timeout counter is cleared on entry to TXWAIT and RXWAIT.
  - It counts every cycle while in those states.
  - Reaching clkf/1000*timeout_ms takes the same path as a mismatch.
  - Counter width is $clog2 of that value plus 1.
- Ownership:
  - In every state except DONE and FAIL, upstream accesses stall: data_m_ack stays 0 and nothing is forwarded.
  - In DONE or FAIL, all m_* outputs equal the upstream inputs combinationally, and data_m_ack / data_m_data_out are m_ack / m_data_in.
- restart in DONE or FAIL:
  - If no upstream access is in flight, clear retries and the status outputs, then go to FLUSH.
  - If an upstream access is in flight, the restart is latched and taken after that access's ack.
- restart in any other state is ignored.

## Timing
- Reset values:
  - State FLUSH; retries, step and timeout are 0.
  - init_done=0, init_failed=0.
  - m_cs, m_access, m_wr_en = 0; m_data_out=0; m_bytesel=0.
  - data_m_ack=0; data_m_data_out=0.
- A transaction costs 2 cycles (strobe, then ack). A poll loop issues back-to-back transactions, one per 2 cycles.
- init_done or init_failed rises on the clock edge that enters DONE or FAIL, and stays high until reset or restart.
- Pass-through adds zero cycles of latency.
- A reset mid-sequence aborts the in-flight transaction. The mouse controller is reset by the same signal.

## Structure
- Shared package ps2_pkg holds:
  - The state enum.
  - Command constants PS2_CMD_RESET=8'hFF and PS2_CMD_ENABLE=8'hF4.
  - Response constants PS2_ACK=8'hFA, PS2_BAT_OK=8'hAA and PS2_MOUSE_ID=8'h00.
  - Status bit indices.
- One sub-module, ps2_port_mux: the combinational ownership mux between upstream and sequencer drives.

## Test plan
- Mouse model replies FA, AA, 00, then FA to F4 → TX bytes FF then F4; init_done=1 after the last READ; init_failed=0.
- First reply is FE instead of FA → sequence restarts from FLUSH with retries=1; a correct second attempt gives init_done.
- Mouse is silent and timeout_ms=1 (shrunk) → three retries then FAIL; init_failed=1; total time about 4 timeouts.
- CPU read asserted at cycle 5 after reset → data_m_ack held 0 until DONE, then completes; the FIFO is not popped by the stalled request.
- In DONE, CPU writes 0x00EB with bytesel 01 → m_data_out=0x00EB and m_bytesel=01 in the same cycle; ack is forwarded the next cycle.
- restart pulse in DONE → init_done falls, FLUSH write 0x8000 is issued, and the full sequence repeats.
